board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
- Sequences the 4x4 game board that feeds the colour decoders and the VGA display path.
- Takes edge-detected button pulses, moves a cursor, paints and clears cells, and loads preset patterns.
- Presents a tear-free 32-bit display_state that updates only at frame boundaries, derived from the sync unit's vsync.
- Sits between the debounce/edge-detect stage and the colour decoders.

Parameters:
- ROWS, 4, board rows.
- COLS, 4, board columns.
- CW, 2, colour code width per cell.
- BLINK_FRAMES, 30, frames per cursor blink half-period; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_up / btn_down / btn_left / btn_right  in  1 each  one-cycle move pulses.
- btn_fire  in  1  one-cycle paint pulse.
- clear_req  in  1  one-cycle request to clear the board.
- load_en  in  1  one-cycle request to load load_data into the board.
- load_data  in  32  preset board pattern.
- color_sel  in  2  colour code written on fire.
- cursor_en  in  1  enables the cursor overlay on display_state.
- vsync  in  1  from the sync unit; active-low; asynchronous to the FSM domain.
- display_state  out  32  committed board plus overlay.
- cursor_row  out  2  current cursor row.
- cursor_col  out  2  current cursor column.
- busy  out  1  high while in CLEAR.
- frame_tick  out  1  one-cycle pulse on each detected vsync falling edge.

Behaviour:
- Cell mapping:
  - idx = row*COLS + col.
  - Cell idx occupies bits [2*idx+1 : 2*idx].
  - Row r occupies bits [8r+7 : 8r].
- Reset (rst low, async) clears all of:
  - board, display_state = 0.
  - cursor_row, cursor_col = 0.
  - busy = 0, frame_tick = 0.
  - blink phase = 0, blink counter = 0.
  - vsync synchroniser flops = 1.
  - FSM = IDLE.
  - A reset mid-CLEAR abandons the clear; the board is zero anyway.
- FSM states:
  - IDLE:
    - Priority is clear_req > load_en > btn_fire > moves; only the highest active request is acted on that cycle.
    - clear_req: go to CLEAR, set the clear counter to 0, assert busy next cycle.
    - load_en: board <= load_data next cycle; stay in IDLE.
    - btn_fire: board[cursor cell] <= color_sel next cycle; stay in IDLE.
  - CLEAR:
    - Write 0 to cell[counter] each cycle; counter increments.
    - After cell 15 is written (16 cycles), return to IDLE; busy drops in the same cycle the state returns to IDLE.
    - All button, load and clear inputs are ignored, not queued.
- Cursor moves (IDLE only, and only when no clear/load/fire is taken that cycle):
  - up: row-1; down: row+1; left: col-1; right: col+1; all modulo 4 (0-1 wraps to 3, 3+1 wraps to 0).
  - up with down in the same cycle: no row change.
  - left with right in the same cycle: no column change.
  - Row and column moves in the same cycle both apply.
  - Cursor updates one cycle after the pulse.
- Frame commit:
  - vsync passes through a 2-flop synchroniser; a falling edge of the synchronised signal gives frame_tick (one cycle).
  - On frame_tick with busy = 0: display_state <= board, with the cursor cell XORed with 2'b11 when cursor_en = 1 and blink phase = 1.
  - On frame_tick with busy = 1: commit is skipped; the display holds the prior frame. The next tick after CLEAR ends commits.
  - Paint latency to screen: the write lands 1 cycle after the pulse and appears at the next frame_tick.
  - A board write in the same cycle as frame_tick commits the pre-write board value.
- Blink:
  - The counter increments on each frame_tick.
  - When it reaches BLINK_FRAMES-1 it resets to 0 and the blink phase toggles.
  - The counter runs regardless of cursor_en and busy.

Decomposition:
- Shared package board_pkg holds:
  - ROWS, COLS, CW.
  - Board width constant (32).
  - FSM state enum {IDLE, CLEAR}.
  - A cell-index function.
- Sub-module frame_sync: the vsync 2-flop synchroniser plus falling-edge detect, producing frame_tick. It is reusable by the display unit.

Test Plan:
- Reset then 4 btn_right pulses: cursor_col goes 1, 2, 3, then 0 (wrap); cursor_row stays 0.
- Cursor at (2,1), color_sel = 2'b10, btn_fire, then one vsync falling edge with cursor_en = 0: display_state[19:18] = 2'b10 and all other bits 0. The commit appears 3 cycles after the vsync edge (2 synchroniser cycles plus 1 commit cycle).
- load_en with load_data = 32'hFFFF_FFFF, then clear_req: busy is high for exactly 16 cycles. A vsync edge during CLEAR leaves display_state = FFFF_FFFF; the next edge after CLEAR gives 0. A btn_fire during CLEAR has no effect.
- Same cycle btn_up + btn_down + btn_left from (0,0): cursor becomes (0,3). clear_req + btn_fire in the same cycle: only CLEAR occurs.
- BLINK_FRAMES = 2, cursor_en = 1, board 0, cursor (0,0): display_state[1:0] over successive frame_ticks is 00, 11, 11, 00, 00.
- Assert rst low mid-CLEAR and asynchronously between clock edges: all outputs are 0 immediately. After release, FSM is IDLE and busy = 0.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the 4x4 game board datapath.
package board_pkg;

   localparam int ROWS    = 4;
   localparam int COLS    = 4;
   localparam int CW      = 2;
   localparam int CELLS   = ROWS * COLS;
   localparam int BOARD_W = CELLS * CW;   // 32

   // Controller FSM: IDLE services requests, CLEAR sweeps the board to zero.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Linear cell index used for the board bit mapping: row*COLS + col.
   function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
      return 4'(int'(row) * COLS + int'(col));
   endfunction

endpackage

// File: rtl/board_controller_frame_sync.sv
// vsync synchroniser plus falling-edge detect; produces a one-cycle frame_tick.
// The third flop holds the previous synchronised value for edge detection.
module frame_sync (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   output logic frame_tick
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   // Two-flop synchroniser and edge history; all flops reset high (vsync idle level).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_1    <= vsync;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   // Falling edge of the synchronised vsync marks the start of a frame.
   always_comb begin
      frame_tick = sync_prev & ~sync_2;
   end

endmodule

// File: rtl/board_controller.sv
// Game board sequencer: cursor movement, painting, clearing, preset loading,
// and a tear-free display_state committed only on frame boundaries.
//
// Request interface: every btn_*, clear_req and load_en input is a one-cycle
// pulse with no acknowledge. A pulse is acted on in the cycle it is high or it
// is dropped (never queued); in IDLE only the highest-priority request is taken
// (clear_req > load_en > btn_fire > moves), and in CLEAR all requests drop.
module board_controller
   import board_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_fire,
   input  logic        clear_req,
   input  logic        load_en,
   input  logic [31:0] load_data,
   input  logic [1:0]  color_sel,
   input  logic        cursor_en,
   input  logic        vsync,
   output logic [31:0] display_state,
   output logic [1:0]  cursor_row,
   output logic [1:0]  cursor_col,
   output logic        busy,
   output logic        frame_tick,
   output logic        state_dbg
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   state_t               state;
   state_t               state_next;
   logic [BOARD_W-1:0]   board;
   logic [BOARD_W-1:0]   board_next;
   logic [1:0]           row_next;
   logic [1:0]           col_next;
   logic [3:0]           clr_cnt;
   logic [3:0]           clr_cnt_next;
   logic [3:0]           cur_idx;
   logic [BOARD_W-1:0]   overlay;
   logic [7:0]           blink_cnt;
   logic [7:0]           blink_cnt_next;
   logic                 blink_phase;

   frame_sync u_frame_sync (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   // Cursor cell index and the busy/debug views of the FSM state.
   always_comb begin
      cur_idx   = cell_idx(cursor_row, cursor_col);
      busy      = (state == CLEAR);
      state_dbg = (state == CLEAR);
   end

   // Next-state logic: request priority in IDLE, cell-by-cell sweep in CLEAR.
   always_comb begin
      state_next   = state;
      board_next   = board;
      row_next     = cursor_row;
      col_next     = cursor_col;
      clr_cnt_next = clr_cnt;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_next   = CLEAR;
               clr_cnt_next = 4'd0;
            end else if (load_en) begin
               board_next = load_data;
            end else if (btn_fire) begin
               board_next[{cur_idx, 1'b0} +: CW] = color_sel;
            end else begin
               // Opposing moves on one axis cancel; the two axes are independent.
               if (btn_up && !btn_down) begin
                  row_next = cursor_row - 2'd1;
               end else if (btn_down && !btn_up) begin
                  row_next = cursor_row + 2'd1;
               end
               if (btn_left && !btn_right) begin
                  col_next = cursor_col - 2'd1;
               end else if (btn_right && !btn_left) begin
                  col_next = cursor_col + 2'd1;
               end
            end
         end
         CLEAR: begin
            board_next[{clr_cnt, 1'b0} +: CW] = '0;
            clr_cnt_next = clr_cnt + 4'd1;
            if (clr_cnt == 4'd15) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM, board, cursor and clear-counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         board      <= '0;
         cursor_row <= 2'd0;
         cursor_col <= 2'd0;
         clr_cnt    <= 4'd0;
      end else begin
         state      <= state_next;
         board      <= board_next;
         cursor_row <= row_next;
         cursor_col <= col_next;
         clr_cnt    <= clr_cnt_next;
      end
   end

   // Board image with the blinking cursor cell inverted.
   always_comb begin
      overlay = board;
      if (cursor_en && blink_phase) begin
         overlay[{cur_idx, 1'b0} +: CW] = board[{cur_idx, 1'b0} +: CW] ^ 2'b11;
      end
   end

   // Commit the pre-write board to the display on each frame tick, except mid-clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         display_state <= '0;
      end else if (frame_tick && !busy) begin
         display_state <= overlay;
      end
   end

   // Blink counter wraps after BLINK_LAST; the phase flips whenever the count lands on BLINK_LAST.
   always_comb begin
      blink_cnt_next = (blink_cnt == BLINK_LAST) ? 8'd0 : blink_cnt + 8'd1;
   end

   // Blink counter and phase advance on every frame tick regardless of busy or cursor_en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= 8'd0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         blink_cnt <= blink_cnt_next;
         if (blink_cnt_next == BLINK_LAST) begin
            blink_phase <= ~blink_phase;
         end
      end
   end

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: table-driven cursor moves plus hand-written
// sequences for paint latency, clear, blink and asynchronous reset.
module tb_board_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_up, btn_down, btn_left, btn_right, btn_fire;
   logic        clear_req, load_en;
   logic [31:0] load_data;
   logic [1:0]  color_sel;
   logic        cursor_en;
   logic        vsync;
   logic [31:0] display_state;
   logic [1:0]  cursor_row, cursor_col;
   logic        busy, frame_tick, state_dbg;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic       up;
      logic       down;
      logic       left;
      logic       right;
      logic [1:0] exp_row;
      logic [1:0] exp_col;
   } mv_t;

   mv_t mv_tab[12];

   board_controller #(.BLINK_FRAMES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_fire      (btn_fire),
      .clear_req     (clear_req),
      .load_en       (load_en),
      .load_data     (load_data),
      .color_sel     (color_sel),
      .cursor_en     (cursor_en),
      .vsync         (vsync),
      .display_state (display_state),
      .cursor_row    (cursor_row),
      .cursor_col    (cursor_col),
      .busy          (busy),
      .frame_tick    (frame_tick),
      .state_dbg     (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic pulse_load(input logic [31:0] data);
      load_data = data;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
   endtask

   task automatic pulse_fire(input logic [1:0] c);
      color_sel = c;
      btn_fire  = 1'b1;
      step();
      btn_fire  = 1'b0;
   endtask

   // Drive one vsync falling edge and compare the committed frame against the queue.
   task automatic do_frame(input string name, input logic [31:0] exp);
      logic got;
      exp_q.push_back(exp);
      vsync = 1'b0;
      got   = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (frame_tick) got = 1'b1;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL %s_tick_timeout: got no frame_tick expected one within 8 cycles", name);
         void'(exp_q.pop_front());
      end else begin
         step();
         check(name, display_state, exp_q.pop_front());
         check({name, "_tick_width"}, {31'd0, frame_tick}, 32'd0);
      end
      vsync = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      int busy_cycles;

      rst = 1'b0;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
      clear_req = 0; load_en = 0; load_data = '0; color_sel = '0;
      cursor_en = 0; vsync = 1'b1;

      // cursor move vectors, applied in order starting from (0,0)
      mv_tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1};
      mv_tab[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2};
      mv_tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3};
      mv_tab[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
      mv_tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3};
      mv_tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3};
      mv_tab[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3};
      mv_tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3};
      mv_tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
      mv_tab[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
      mv_tab[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0};
      mv_tab[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_display", display_state, 32'd0);
      check("rst_row", {30'd0, cursor_row}, 32'd0);
      check("rst_col", {30'd0, cursor_col}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // table-driven cursor moves
      for (int i = 0; i < 12; i++) begin
         btn_up = mv_tab[i].up; btn_down = mv_tab[i].down;
         btn_left = mv_tab[i].left; btn_right = mv_tab[i].right;
         step();
         btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
         check($sformatf("move%0d_row", i), {30'd0, cursor_row}, {30'd0, mv_tab[i].exp_row});
         check($sformatf("move%0d_col", i), {30'd0, cursor_col}, {30'd0, mv_tab[i].exp_col});
      end

      // paint at (2,1) and check commit latency from the vsync edge
      pulse_fire(2'b10);
      exp_q.push_back(32'h0008_0000);
      vsync = 1'b0;
      step();
      check("paint_lat1", display_state, 32'd0);
      step();
      check("paint_lat2", display_state, 32'd0);
      step();
      check("paint_commit", display_state, exp_q.pop_front());
      vsync = 1'b1;
      repeat (4) step();

      // load all ones, then clear with fire in the same cycle
      pulse_load(32'hFFFF_FFFF);
      do_frame("load_frame", 32'hFFFF_FFFF);
      clear_req = 1'b1;
      btn_fire  = 1'b1;
      color_sel = 2'b01;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 0) begin
            clear_req = 1'b0;
            btn_fire  = 1'b0;
         end
         if (i == 1) btn_fire = 1'b1;
         if (i == 2) begin
            btn_fire  = 1'b0;
            load_data = 32'h5555_5555;
            load_en   = 1'b1;
         end
         if (i == 3) begin
            load_en = 1'b0;
            exp_q.push_back(32'hFFFF_FFFF);
            vsync   = 1'b0;
         end
         if (i == 9) vsync = 1'b1;
         if (busy) busy_cycles++;
      end
      check("busy_cycles", busy_cycles, 32'd16);
      check("display_held_in_clear", display_state, exp_q.pop_front());
      check("idle_after_clear", {31'd0, state_dbg}, 32'd0);
      do_frame("frame_after_clear", 32'd0);

      // asynchronous reset in the middle of a clear
      pulse_load(32'hA5A5_A5A5);
      do_frame("preset_frame", 32'hA5A5_A5A5);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (5) step();
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #3;
      rst = 1'b0;
      #1;
      check("arst_display", display_state, 32'd0);
      check("arst_row", {30'd0, cursor_row}, 32'd0);
      check("arst_col", {30'd0, cursor_col}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_tick", {31'd0, frame_tick}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_state", {31'd0, state_dbg}, 32'd0);
      do_frame("post_rst_frame", 32'd0);

      // blink with BLINK_FRAMES = 2 from a fresh reset, cursor at (0,0)
      apply_reset();
      cursor_en = 1'b1;
      do_frame("blink0", 32'h0000_0000);
      do_frame("blink1", 32'h0000_0003);
      do_frame("blink2", 32'h0000_0003);
      do_frame("blink3", 32'h0000_0000);
      do_frame("blink4", 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
